seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Multiplexed 7-segment display driver: the reader of the BCD digit outputs produced by the
//   chained decade counters. Latches a coherent snapshot of NUM_DIG BCD digits once per frame,
//   time-multiplexes them onto one shared segment bus with one digit-select line per digit, and
//   applies leading-zero blanking, invalid-code marking and inter-digit anti-ghost blanking.
// PARAMETERS
//   NUM_DIG        4      number of digits (2..8); digit 0 = least significant
//   SCAN_DIV       50000  clk cycles per digit slot (>= 2)
//   BLANK_CYC      500    cycles at start of each slot with all selects inactive (< SCAN_DIV)
//   SEG_ACTIVE_LOW 1      1: seg/dp outputs inverted (common anode)
//   SEL_ACTIVE_LOW 1      1: sel outputs inverted
//   BLANK_LZ       1      1: enable leading-zero blanking
// PORTS
//   clk     in   1          system clock
//   rst_n   in   1          asynchronous active-low reset
//   en      in   1          1: scan/display; 0: display dark, scan held
//   bcd_in  in   4*NUM_DIG  digit k at bcd_in[4k+3:4k]
//   dp_in   in   NUM_DIG    decimal point request for digit k
//   seg     out  7          segments {g,f,e,d,c,b,a}, seg[0]=a
//   dp      out  1          decimal point segment
//   sel     out  NUM_DIG    digit select, sel[k] drives digit k
// BEHAVIOUR
//   - Reset (async, rst_n=0): prescaler cnt=0, slot idx=0, shadow regs=0, load_pend=1; seg, dp, sel
//     all at inactive level (seg=7'h7F, dp=1, sel all 1s when active-low). Release takes effect on
//     the next clk edge.
//   - Prescaler: when en=1, cnt counts 0..SCAN_DIV-1 and wraps; at cnt==SCAN_DIV-1, idx advances
//     (NUM_DIG-1 wraps to 0).
//   - Snapshot: shadow_bcd/shadow_dp load bcd_in/dp_in on the edge where idx wraps to 0, and on
//     the first enabled cycle after reset or after en rises (load_pend). No other time: input
//     changes mid-frame never appear until the next frame.
//   - Decode (internal active-high): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F;
//     codes 10..15 -> 7'h40 (dash). Blank = 7'h00.
//   - Leading-zero blanking (BLANK_LZ=1): digit k>=1 blanked (seg and dp off) when shadow digits
//     k..NUM_DIG-1 are all 0 and dp for those digits is 0. Digit 0 is never blanked. Dash codes
//     count as non-zero.
//   - Slot output: if cnt < BLANK_CYC all sel inactive, seg/dp inactive; else sel one-hot at idx,
//     seg/dp = decode of shadow digit idx after blanking. Outputs registered: 1-cycle latency from
//     cnt/idx/shadow state.
//   - Polarity: seg,dp inverted when SEG_ACTIVE_LOW=1; sel inverted when SEL_ACTIVE_LOW=1.
//   - en=0: cnt and idx forced to 0, load_pend set; outputs go inactive on the next edge. en
//     rising restarts scan at digit 0 slot start (blank phase first) with a fresh snapshot.
//   - Reset asserted mid-scan: outputs inactive immediately (async), no partial frame resumes.
//   - Never more than one sel active in any cycle; no sel active during the blank phase.
// TESTING (bench params: NUM_DIG=4, SCAN_DIV=4, BLANK_CYC=1, both polarities active-low)
//   1. rst_n=0, any inputs -> seg=7'h7F, dp=1, sel=4'hF; hold through 10 clk edges.
//   2. en=1, bcd_in=16'h1234, dp_in=0 -> slot sequence sel 1110/1101/1011/0111 with seg =
//      ~66,~4F,~5B,~06 (7'h19,30,24,79); 1 cycle sel=4'hF at each slot start; period 16 cycles.
//   3. bcd_in=16'h0050 -> digits 3,2 blank (seg=7'h7F while selected), digit1 7'h12, digit0 7'h40;
//      bcd_in=0,dp_in=4'b0100 -> digit2 shows '0' with dp=0, digit3 blank.
//   4. bcd_in 16'h1234 -> 16'h5678 at idx=1 -> digits 1..3 still show 3,2,1; 5678 from next frame.
//   5. bcd_in=16'hABCF -> every selected digit seg=~7'h40=7'h3F, none blanked.
//   6. en low at idx=2 -> next cycle sel=4'hF; en high -> digit0 slot after 1 blank cycle, new
//      snapshot; rst_n pulse mid-slot -> outputs inactive same cycle, scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bundle between the BCD digit source and the 7-segment scan driver.
// Latency: n/a (wires only).
// Backpressure: none; the source drives levels, the driver samples them once per frame.
//
// Ports / signals:
//   en      source -> driver   1: scan and display, 0: display dark
//   bcd_in  source -> driver   digit k at bcd_in[4k+3:4k], digit 0 least significant
//   dp_in   source -> driver   decimal point request per digit
//   seg     driver -> panel    segments {g,f,e,d,c,b,a}, physical level
//   dp      driver -> panel    decimal point segment, physical level
//   sel     driver -> panel    digit selects, sel[k] drives digit k, physical level
interface seg7_scan_if #(
   parameter int NUM_DIG = 4
);
   logic                   en;
   logic [4*NUM_DIG-1:0]   bcd_in;
   logic [NUM_DIG-1:0]     dp_in;
   logic [6:0]             seg;
   logic                   dp;
   logic [NUM_DIG-1:0]     sel;

   modport master (
      output en, bcd_in, dp_in,
      input  seg, dp, sel
   );

   modport slave (
      input  en, bcd_in, dp_in,
      output seg, dp, sel
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: per-frame digit snapshot, LZ blanking, dash for bad codes.
// Latency: outputs registered, one cycle after the prescaler/slot/snapshot state.
// Backpressure: none; inputs are sampled only at frame start, never stalled.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, all outputs forced to their inactive level
//   bus    seg7_scan_if.slave: en/bcd_in/dp_in in, seg/dp/sel out
module seg7_scan_driver #(
   parameter int NUM_DIG        = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int BLANK_CYC      = 500,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit SEL_ACTIVE_LOW = 1'b1,
   parameter bit BLANK_LZ       = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   seg7_scan_if.slave  bus
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

   // Physical levels for "everything off".
   localparam logic [6:0]         SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic               DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIG-1:0] SEL_OFF = {NUM_DIG{SEL_ACTIVE_LOW}};

   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [4*NUM_DIG-1:0] shadow_bcd_q, shadow_bcd_d;
   logic [NUM_DIG-1:0]   shadow_dp_q, shadow_dp_d;
   logic                 load_pend_q, load_pend_d;
   logic [6:0]           seg_q, seg_d;
   logic                 dp_q, dp_d;
   logic [NUM_DIG-1:0]   sel_q, sel_d;

   logic                 slot_end;
   logic                 frame_end;
   logic [NUM_DIG-1:0]   lz_blank;
   logic                 zero_run;
   logic [3:0]           cur_bcd;
   logic                 cur_dp;
   logic                 cur_blank;
   logic [6:0]           seg_act;
   logic                 dp_act;
   logic [NUM_DIG-1:0]   sel_act;

   // Active-high glyphs; codes 10..15 show a dash so a bad digit is visible.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'd0:    g = 7'h3F;
         4'd1:    g = 7'h06;
         4'd2:    g = 7'h5B;
         4'd3:    g = 7'h4F;
         4'd4:    g = 7'h66;
         4'd5:    g = 7'h6D;
         4'd6:    g = 7'h7D;
         4'd7:    g = 7'h07;
         4'd8:    g = 7'h7F;
         4'd9:    g = 7'h6F;
         default: g = 7'h40;
      endcase
      return g;
   endfunction

   // Leading-zero mask: walk down from the most significant digit while the
   // digit and its decimal point are both zero. Digit 0 is never blanked.
   always_comb begin
      zero_run = 1'b1;
      lz_blank = '0;
      for (int k = NUM_DIG - 1; k >= 1; k--) begin
         zero_run    = zero_run & (shadow_bcd_q[4*k +: 4] == 4'd0) & ~shadow_dp_q[k];
         lz_blank[k] = zero_run & BLANK_LZ;
      end
   end

   // Select the digit for the current slot without a variable part-select.
   always_comb begin
      cur_bcd   = 4'd0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int k = 0; k < NUM_DIG; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_bcd   = shadow_bcd_q[4*k +: 4];
            cur_dp    = shadow_dp_q[k];
            cur_blank = lz_blank[k];
         end
      end
   end

   always_comb begin
      slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
      frame_end = slot_end && (idx_q == IDX_W'(NUM_DIG - 1));

      cnt_d        = cnt_q;
      idx_d        = idx_q;
      shadow_bcd_d = shadow_bcd_q;
      shadow_dp_d  = shadow_dp_q;
      load_pend_d  = load_pend_q;

      if (!bus.en) begin
         // Scan held at digit 0 slot start; next enable takes a fresh snapshot.
         cnt_d       = '0;
         idx_d       = '0;
         load_pend_d = 1'b1;
      end else begin
         if (load_pend_q || frame_end) begin
            shadow_bcd_d = bus.bcd_in;
            shadow_dp_d  = bus.dp_in;
            load_pend_d  = 1'b0;
         end
         if (slot_end) begin
            cnt_d = '0;
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Blank phase at slot start keeps all selects off so the previous
      // digit's segments cannot ghost onto the next digit.
      seg_act = '0;
      dp_act  = 1'b0;
      sel_act = '0;
      if (bus.en && (cnt_q >= CNT_W'(BLANK_CYC))) begin
         sel_act = NUM_DIG'(1) << idx_q;
         if (!cur_blank) begin
            seg_act = decode(cur_bcd);
            dp_act  = cur_dp;
         end
      end

      seg_d = seg_act ^ SEG_OFF;
      dp_d  = dp_act ^ DP_OFF;
      sel_d = sel_act ^ SEL_OFF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_bcd_q <= '0;
         shadow_dp_q  <= '0;
         load_pend_q  <= 1'b1;
         seg_q        <= SEG_OFF;
         dp_q         <= DP_OFF;
         sel_q        <= SEL_OFF;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_bcd_q <= shadow_bcd_d;
         shadow_dp_q  <= shadow_dp_d;
         load_pend_q  <= load_pend_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         sel_q        <= sel_d;
      end
   end

   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
   assign bus.sel = sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: frame-position model checked every cycle plus literal expectations.
// Latency: model output follows the enabled-cycle position before each edge.
// Backpressure: none.
module tb_seg7_scan_driver;
   localparam int ND    = 4;
   localparam int DIV   = 4;
   localparam int BLK   = 1;
   localparam int FRAME = ND * DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   seg7_scan_if #(.NUM_DIG(ND)) bus();

   seg7_scan_driver #(
      .NUM_DIG(ND), .SCAN_DIV(DIV), .BLANK_CYC(BLK),
      .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'd0: g = 7'h3F; 4'd1: g = 7'h06; 4'd2: g = 7'h5B; 4'd3: g = 7'h4F;
         4'd4: g = 7'h66; 4'd5: g = 7'h6D; 4'd6: g = 7'h7D; 4'd7: g = 7'h07;
         4'd8: g = 7'h7F; 4'd9: g = 7'h6F;
         default: g = 7'h40;
      endcase
      return g;
   endfunction

   // Physical {seg, dp, sel} for digit d of a snapshot: anything above the
   // most significant "interesting" digit (non-zero value or dp) is dark.
   function automatic logic [11:0] expect_phys(input int d, input logic [15:0] b, input logic [3:0] p);
      int msd;
      logic [6:0] s;
      logic pt;
      logic [3:0] sl;
      msd = 0;
      for (int k = 0; k < ND; k++)
         if (b[4*k +: 4] != 4'd0 || p[k]) msd = k;
      s  = glyph(b[4*d +: 4]);
      pt = p[d];
      if (d > msd) begin
         s  = 7'h00;
         pt = 1'b0;
      end
      sl = 4'b0001 << d;
      return {~s, ~pt, ~sl};
   endfunction

   int          m_pos = 0;
   logic [15:0] m_bcd = '0;
   logic [3:0]  m_dp  = '0;
   logic [6:0]  e_seg = 7'h7F;
   logic        e_dp  = 1'b1;
   logic [3:0]  e_sel = 4'hF;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos <= 0;
         m_bcd <= '0;
         m_dp  <= '0;
         e_seg <= 7'h7F;
         e_dp  <= 1'b1;
         e_sel <= 4'hF;
      end else if (!bus.en) begin
         m_pos <= 0;
         e_seg <= 7'h7F;
         e_dp  <= 1'b1;
         e_sel <= 4'hF;
      end else begin
         if ((m_pos % DIV) < BLK) begin
            e_seg <= 7'h7F;
            e_dp  <= 1'b1;
            e_sel <= 4'hF;
         end else begin
            {e_seg, e_dp, e_sel} <= expect_phys((m_pos / DIV) % ND, m_bcd, m_dp);
         end
         if (m_pos == 0 || (m_pos % FRAME) == FRAME - 1) begin
            m_bcd <= bus.bcd_in;
            m_dp  <= bus.dp_in;
         end
         m_pos <= m_pos + 1;
      end
   end

   always @(negedge clk) begin
      check("model_seg", 32'(bus.seg), 32'(e_seg));
      check("model_dp",  32'(bus.dp),  32'(e_dp));
      check("model_sel", 32'(bus.sel), 32'(e_sel));
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic lit(input string name, input logic [6:0] s, input logic p, input logic [3:0] sl);
      check({name, "_seg"}, 32'(bus.seg), 32'(s));
      check({name, "_dp"},  32'(bus.dp),  32'(p));
      check({name, "_sel"}, 32'(bus.sel), 32'(sl));
   endtask

   task automatic restart(input logic [15:0] b, input logic [3:0] p);
      bus.en = 1'b0;
      @(negedge clk);
      bus.bcd_in = b;
      bus.dp_in  = p;
      bus.en     = 1'b1;
   endtask

   // segs packed d3..d0 at [7d +: 7]; dps[d] physical level.
   task automatic frame_check(input string name, input logic [15:0] b, input logic [3:0] p,
                              input logic [27:0] segs, input logic [3:0] dps);
      logic [3:0] sl;
      restart(b, p);
      step(1);
      lit({name, "_blank"}, 7'h7F, 1'b1, 4'hF);
      for (int d = 0; d < ND; d++) begin
         step(d == 0 ? 1 : 4);
         sl = 4'b0001 << d;
         lit($sformatf("%s_d%0d", name, d), segs[7*d +: 7], dps[d], ~sl);
      end
   endtask

   initial begin
      bus.en     = 1'b0;
      bus.bcd_in = 16'h1234;
      bus.dp_in  = 4'h0;
      #1 rst_n = 1'b0;
      bus.en = 1'b1;
      repeat (10) begin
         @(negedge clk);
         lit("reset", 7'h7F, 1'b1, 4'hF);
      end
      rst_n = 1'b1;

      // Plain number, then period of one frame.
      frame_check("n1234", 16'h1234, 4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
      step(4);
      lit("period", 7'h19, 1'b1, 4'b1110);

      // Leading-zero blanking and the dp exception.
      frame_check("n0050", 16'h0050, 4'h0, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
      frame_check("dp2",   16'h0000, 4'b0100, {7'h7F, 7'h40, 7'h40, 7'h40}, 4'b1011);

      // Invalid codes show a dash and are never blanked.
      frame_check("dash", 16'hABCF, 4'h0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'hF);

      // Mid-frame input change waits for the next frame.
      restart(16'h1234, 4'h0);
      step(2);
      step(4);
      lit("mid_d1", 7'h30, 1'b1, 4'b1101);
      bus.bcd_in = 16'h5678;
      step(4);
      lit("mid_d2", 7'h24, 1'b1, 4'b1011);
      step(4);
      lit("mid_d3", 7'h79, 1'b1, 4'b0111);
      step(4);
      lit("new_d0", 7'h00, 1'b1, 4'b1110);
      step(4);
      lit("new_d1", 7'h78, 1'b1, 4'b1101);

      // Enable drop at digit 2, then re-enable with a fresh snapshot.
      restart(16'h1234, 4'h0);
      step(10);
      lit("en_d2", 7'h24, 1'b1, 4'b1011);
      bus.en = 1'b0;
      step(1);
      lit("en_off", 7'h7F, 1'b1, 4'hF);
      bus.bcd_in = 16'h0009;
      bus.en     = 1'b1;
      step(1);
      lit("en_blank", 7'h7F, 1'b1, 4'hF);
      step(1);
      lit("en_d0", 7'h10, 1'b1, 4'b1110);

      // Asynchronous reset mid-slot.
      step(1);
      #2 rst_n = 1'b0;
      #1 lit("async_rst", 7'h7F, 1'b1, 4'hF);
      @(negedge clk);
      rst_n = 1'b1;
      step(1);
      lit("rst_blank", 7'h7F, 1'b1, 4'hF);
      step(1);
      lit("rst_d0", 7'h10, 1'b1, 4'b1110);
      step(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
